rename_queue: RTL and testbench
===============================

Name: rename_queue

Overview:
- Bundle-granular FIFO between decode and the rename stage. Holds up to DEPTH bundles of RENAME_WIDTH micro-ops.
- Presents the head bundle to rename with a valid/ready handshake.
- Drops all-invalid bundles, and flushes completely on branch-mispredict recovery.
- Decouples decode throughput from rename stalls: RAT busy cycles and checkpoint-full or free-list-empty back-pressure.

Parameters:
- DEPTH, 8, number of bundle entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), head/tail pointer width (derived, not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  mispredict recovery; discard all contents
- in_valid  in  1  decode presents a bundle
- in_ready  out  1  queue accepts a bundle this cycle
- uop_in  in  RENAME_WIDTH x micro_op_t  decoded bundle
- out_valid  out  1  head bundle available
- out_ready  in  1  rename consumes the head (RAT ready & allocatable)
- uop_out  out  RENAME_WIDTH x micro_op_t  head bundle
- count  out  PTR_W+1  number of occupied entries

Behaviour:
- Storage: DEPTH x RENAME_WIDTH micro_op_t array, plus head, tail (PTR_W) and count (PTR_W+1) registers.
- Pointers wrap modulo DEPTH naturally.
- Reset: head=0, tail=0, count=0. Therefore out_valid=0, in_ready=1, count=0, and every uop_out[i].valid=0.
  - Storage contents are not reset.
  - Reset asserted mid-traffic discards everything on the next edge, exactly like flush.
- in_ready = (count != DEPTH) & ~flush. Purely from current state; no same-cycle dequeue credit.
- Enqueue fires when in_valid & in_ready & (|uop_in[*].valid).
  - Writes the entry at tail; tail+1; count+1.
  - If in_valid & in_ready but all uop_in[i].valid=0, the bundle is consumed (handshake completes) but not stored.
- Dequeue fires when out_valid & out_ready. head+1; count-1.
- out_valid = (count != 0) & ~flush.
- uop_out = storage[head], with every .valid bit ANDed with out_valid. Read is combinational from registers.
- Latency: a bundle enqueued at edge N is visible at uop_out in cycle N+1 at the earliest. There is no empty bypass.
- Simultaneous enqueue and dequeue: count unchanged, head and tail both advance.
  - This is legal whenever count is between 1 and DEPTH-1.
  - At count=DEPTH, in_ready=0 so only the dequeue occurs.
- flush has priority over all else. On the next edge head=tail=0 and count=0.
  - Enqueue and dequeue in the flush cycle are suppressed, since in_ready=0 and out_valid=0 combinationally.
  - Decode must drop its bundle in that cycle.
- Bundle contents pass through unmodified. No field other than the output .valid masking is altered.
- Assertion checks for verification:
  - count ≤ DEPTH always.
  - count == (tail - head) mod DEPTH, except when full (count==DEPTH and head==tail).
  - out_ready while out_valid=0 has no effect.

Decomposition:
- micro_op_t, RENAME_WIDTH and BR_X stay in the shared micro-op package header.
- Add a queue-depth constant to the shared package for core-level tuning.
- One natural sub-module: bundle_fifo_ctrl, covering pointer/count update and the full/empty/flush logic. The top level holds the storage array and the valid masking.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, count=0, all uop_out[i].valid=0.
- Enqueue 8 valid bundles, out_ready=0 -> count=8, in_ready=0 after the 8th edge; a 9th in_valid is not accepted; then out_ready=1 for 8 cycles drains them in order (pc tags match), count returns to 0.
- Continuous in_valid and out_ready=1 with count=3 -> count stays 3 each cycle; order preserved across pointer wrap after ≥10 bundles.
- Bundle with all valid=0 at count=2 -> in_ready handshake completes, count stays 2, bundle never appears at uop_out.
- flush at count=5 with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0; next enqueued bundle is output one cycle after enqueue.
- reset asserted at count=6 during simultaneous enqueue/dequeue -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/rename_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : rename_queue_pkg
// Brief  : Shared micro-op types and rename-queue tuning constants.
// Rev    : 1.0
// ============================================================================
package rename_queue_pkg;

    localparam int RENAME_WIDTH       = 4;
    localparam int BR_X               = 4;
    localparam int RENAME_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [BR_X-1:0] br_tag;
    } micro_op_t;

    typedef micro_op_t [RENAME_WIDTH-1:0] uop_bundle_t;

    function automatic logic bundle_any_valid(input uop_bundle_t b);
        logic any;
        any = 1'b0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            any = any | b[i].valid;
        end
        return any;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rename_queue_if.sv
`default_nettype none
// ============================================================================
// Module : rename_queue_if
// Brief  : Decode-side and rename-side handshake bundle for the rename queue.
// Rev    : 1.0
// ============================================================================
interface rename_queue_if
    import rename_queue_pkg::*;
#(
    parameter int DEPTH = RENAME_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    uop_bundle_t     uop_in;
    logic            out_valid;
    logic            out_ready;
    uop_bundle_t     uop_out;
    logic [PTR_W:0]  count;

    modport master (
        output flush, in_valid, uop_in, out_ready,
        input  in_ready, out_valid, uop_out, count
    );

    modport slave (
        input  flush, in_valid, uop_in, out_ready,
        output in_ready, out_valid, uop_out, count
    );
endinterface
`default_nettype wire

// File: rtl/rename_queue_bundle_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bundle_fifo_ctrl
// Brief  : Head/tail/count bookkeeping with full, empty and flush handling.
// Rev    : 1.0
// ============================================================================
module bundle_fifo_ctrl #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             flush,
    input  wire logic             in_valid,
    input  wire logic             in_any_valid,
    input  wire logic             out_ready,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  enq,
    output logic [PTR_W-1:0]      head,
    output logic [PTR_W-1:0]      tail,
    output logic [PTR_W:0]        count
);
    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_diff;
    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);
    assign w_diff    = r_tail - r_head;

    // Readiness depends only on current occupancy; a same-cycle dequeue gives no credit.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = ~w_empty & ~flush;

    // All-invalid bundles complete the handshake without occupying an entry.
    assign w_enq     = in_valid & in_ready & in_any_valid;
    assign w_deq     = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + C_PTR_ONE;
            if (w_deq) r_head <= r_head + C_PTR_ONE;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign enq   = w_enq;
    assign head  = r_head;
    assign tail  = r_tail;
    assign count = r_count;

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        r_count <= C_FULL);

    a_count_ptrs: assert property (@(posedge clock) disable iff (reset)
        (w_full ? (r_head == r_tail) : (r_count == {1'b0, w_diff})));

    a_idle_ready: assert property (@(posedge clock)
        (!reset && !flush && !out_valid && out_ready) |=> (r_head == $past(r_head)));

endmodule
`default_nettype wire

// File: rtl/rename_queue.sv
`default_nettype none
// ============================================================================
// Module : rename_queue
// Brief  : Bundle FIFO between decode and rename; holds storage and masks valids.
// Rev    : 1.0
// ============================================================================
module rename_queue
    import rename_queue_pkg::*;
#(
    parameter int DEPTH = RENAME_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic      clock,
    input  wire logic      reset,
    rename_queue_if.slave  bus
);
    uop_bundle_t      r_mem [DEPTH];
    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic [PTR_W:0]   w_count;
    logic             w_enq;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_any_valid;
    uop_bundle_t      w_head_bundle;

    assign w_any_valid = bundle_any_valid(bus.uop_in);

    bundle_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .flush        (bus.flush),
        .in_valid     (bus.in_valid),
        .in_any_valid (w_any_valid),
        .out_ready    (bus.out_ready),
        .in_ready     (w_in_ready),
        .out_valid    (w_out_valid),
        .enq          (w_enq),
        .head         (w_head),
        .tail         (w_tail),
        .count        (w_count)
    );

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[w_tail] <= bus.uop_in;
        end
    end

    // Stale storage behind an empty or flushing queue must never look like live micro-ops.
    always_comb begin
        w_head_bundle = r_mem[w_head];
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w_head_bundle[i].valid = r_mem[w_head][i].valid & w_out_valid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.uop_out   = w_head_bundle;
    assign bus.count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_rename_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_rename_queue
// Brief  : Directed and random stimulus against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_rename_queue;
    import rename_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   seq;

    uop_bundle_t mq[$];

    rename_queue_if #(.DEPTH(DEPTH)) bus ();

    rename_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RENAME_WIDTH-1:0] vbits(input uop_bundle_t b);
        logic [RENAME_WIDTH-1:0] v;
        for (int i = 0; i < RENAME_WIDTH; i++) v[i] = b[i].valid;
        return v;
    endfunction

    // keep_valid=1 guarantees at least one live lane; 0 produces an all-invalid bundle.
    function automatic uop_bundle_t mk(input bit keep_valid);
        uop_bundle_t b;
        seq++;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            b[i].valid  = keep_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            b[i].pc     = (32'(seq) << 4) | 32'(i);
            b[i].opcode = 7'($urandom);
            b[i].rd     = 5'($urandom);
            b[i].rs1    = 5'($urandom);
            b[i].rs2    = 5'($urandom);
            b[i].br_tag = BR_X'($urandom);
        end
        if (keep_valid && vbits(b) == '0) b[0].valid = 1'b1;
        return b;
    endfunction

    task automatic cycle(input logic iv, input uop_bundle_t b, input logic ordy,
                         input logic fl, input logic rst);
        logic exp_ir;
        logic exp_ov;
        @(negedge clock);
        bus.in_valid  = iv;
        bus.uop_in    = b;
        bus.out_ready = ordy;
        bus.flush     = fl;
        reset         = rst;
        #1;
        exp_ir = (mq.size() != DEPTH) && !fl;
        exp_ov = (mq.size() != 0) && !fl;
        check("in_ready", 256'(bus.in_ready), 256'(exp_ir));
        check("out_valid", 256'(bus.out_valid), 256'(exp_ov));
        check("count", 256'(bus.count), 256'(mq.size()));
        if (exp_ov) check("uop_out", 256'(bus.uop_out), 256'(mq[0]));
        else        check("uop_out_valid", 256'(vbits(bus.uop_out)), 256'(0));
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (exp_ov && ordy) void'(mq.pop_front());
            if (iv && exp_ir && vbits(b) != '0) mq.push_back(b);
        end
    endtask

    task automatic fill(input int n);
        repeat (n) cycle(1'b1, mk(1'b1), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, mk(1'b1), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        seq           = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.uop_in    = '0;
        repeat (3) @(posedge clock);
        mq.delete();

        // Idle after reset.
        cycle(1'b0, mk(1'b1), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, mk(1'b1), 1'b1, 1'b0, 1'b0);

        // Fill to full, attempt a ninth, then drain in order.
        fill(DEPTH);
        cycle(1'b1, mk(1'b1), 1'b0, 1'b0, 1'b0);
        drain(DEPTH);
        cycle(1'b0, mk(1'b1), 1'b0, 1'b0, 1'b0);

        // Steady state at three entries across pointer wrap.
        fill(3);
        repeat (12) cycle(1'b1, mk(1'b1), 1'b1, 1'b0, 1'b0);
        drain(3);

        // All-invalid bundle at count 2 is consumed but never stored.
        fill(2);
        cycle(1'b1, mk(1'b0), 1'b0, 1'b0, 1'b0);
        drain(3);

        // Flush at count 5 with both sides active, then single-cycle latency.
        fill(5);
        cycle(1'b1, mk(1'b1), 1'b1, 1'b1, 1'b0);
        cycle(1'b1, mk(1'b1), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, mk(1'b1), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, mk(1'b1), 1'b0, 1'b0, 1'b0);

        // Reset at count 6 during simultaneous enqueue/dequeue.
        fill(6);
        cycle(1'b1, mk(1'b1), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, mk(1'b1), 1'b0, 1'b0, 1'b0);

        // Random traffic with varying back-pressure, occasional flush and reset.
        for (int blk = 0; blk < 8; blk++) begin
            int ordy_pct;
            ordy_pct = (blk % 2 == 0) ? 30 : 80;
            for (int k = 0; k < 80; k++) begin
                cycle(1'($urandom_range(0, 3) != 0),
                      mk(1'($urandom_range(0, 7) != 0)),
                      1'($urandom_range(0, 99) < ordy_pct),
                      1'($urandom_range(0, 40) == 0),
                      1'($urandom_range(0, 80) == 0));
            end
        end
        drain(DEPTH + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
